// File: rtl/accumulator_unit.sv
// Accumulator execute stage for the register-file datapath: one operation per accepted
// start, LD/ST/ALU ops resolve in a single EXEC cycle, MUL runs an iterative shift-add.
`timescale 1ns/1ps

module accumulator_unit #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] reg_addr_in,
    input  logic [DATA_W-1:0] register_value,
    output logic [ADDR_W-1:0] register_address,
    output logic              ce,
    output logic [DATA_W-1:0] accumulator_input,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              zero,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_ST  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_op,     w_op_next;
    logic [ADDR_W-1:0]   r_addr,   w_addr_next;
    logic [DATA_W-1:0]   r_acc,    w_acc_next;
    logic                r_carry,  w_carry_next;
    logic [DATA_W-1:0]   r_mcand,  w_mcand_next;
    logic [DATA_W-1:0]   r_mplier, w_mplier_next;
    logic [PROD_W-1:0]   r_prod,   w_prod_next;
    logic [CNT_W-1:0]    r_cnt,    w_cnt_next;

    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [PROD_W-1:0]   w_addend;
    logic [PROD_W-1:0]   w_prod_sum;
    logic                w_last_iter;

    // Zero-extended so the top bit is carry for ADD and borrow (R > acc) for SUB.
    assign w_sum       = {1'b0, r_acc} + {1'b0, register_value};
    assign w_diff      = {1'b0, r_acc} - {1'b0, register_value};
    assign w_addend    = r_mplier[0] ? (PROD_W'(r_mcand) << r_cnt) : '0;
    assign w_prod_sum  = r_prod + w_addend;
    assign w_last_iter = (r_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_op_next     = r_op;
        w_addr_next   = r_addr;
        w_acc_next    = r_acc;
        w_carry_next  = r_carry;
        w_mcand_next  = r_mcand;
        w_mplier_next = r_mplier;
        w_prod_next   = r_prod;
        w_cnt_next    = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_EXEC;
                    w_op_next    = opcode;
                    w_addr_next  = reg_addr_in;
                end
            end
            S_EXEC: begin
                w_state_next = S_DONE;
                case (r_op)
                    OP_LD:  w_acc_next = register_value;
                    OP_ADD: begin
                        w_acc_next   = w_sum[DATA_W-1:0];
                        w_carry_next = w_sum[DATA_W];
                    end
                    OP_SUB: begin
                        w_acc_next   = w_diff[DATA_W-1:0];
                        w_carry_next = w_diff[DATA_W];
                    end
                    OP_AND: begin
                        w_acc_next   = r_acc & register_value;
                        w_carry_next = 1'b0;
                    end
                    OP_XOR: begin
                        w_acc_next   = r_acc ^ register_value;
                        w_carry_next = 1'b0;
                    end
                    OP_MUL: begin
                        w_state_next  = S_MUL;
                        w_mcand_next  = r_acc;
                        w_mplier_next = register_value;
                        w_prod_next   = '0;
                        w_cnt_next    = '0;
                    end
                    OP_NOP, OP_ST: ;
                    default: ;
                endcase
            end
            S_MUL: begin
                // Final iteration commits from the just-formed sum, not the stale product.
                w_prod_next   = w_prod_sum;
                w_mplier_next = r_mplier >> 1;
                w_cnt_next    = r_cnt + CNT_W'(1);
                if (w_last_iter) begin
                    w_state_next = S_DONE;
                    w_acc_next   = w_prod_sum[DATA_W-1:0];
                    w_carry_next = |w_prod_sum[PROD_W-1:DATA_W];
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_NOP;
            r_addr   <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else begin
            r_op     <= w_op_next;
            r_addr   <= w_addr_next;
            r_acc    <= w_acc_next;
            r_carry  <= w_carry_next;
            r_mcand  <= w_mcand_next;
            r_mplier <= w_mplier_next;
            r_prod   <= w_prod_next;
            r_cnt    <= w_cnt_next;
        end
    end

    // Status and write strobe decode straight from the state register.
    assign ce                = (r_state == S_EXEC) && (r_op == OP_ST);
    assign busy              = (r_state != S_IDLE);
    assign done              = (r_state == S_DONE);
    assign zero              = (r_acc == '0);
    assign acc               = r_acc;
    assign carry             = r_carry;
    assign accumulator_input = r_acc;
    assign register_address  = r_addr;

endmodule

// File: tb/tb_accumulator_unit.sv
// Scoreboard bench for accumulator_unit: driver pushes expected results from an
// arithmetic model at accept time; a monitor pops and compares on every done pulse.
`timescale 1ns/1ps

module tb_accumulator_unit;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned MUL_BUSY = DATA_W + 2;

    localparam logic [2:0] NOP = 3'd0, LD = 3'd1, ST = 3'd2, ADD = 3'd3;
    localparam logic [2:0] SUB = 3'd4, AND = 3'd5, XOR = 3'd6, MUL = 3'd7;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] reg_addr_in;
    logic [DATA_W-1:0] register_value;
    logic [ADDR_W-1:0] register_address;
    logic              ce;
    logic [DATA_W-1:0] accumulator_input;
    logic [DATA_W-1:0] acc;
    logic              carry;
    logic              zero;
    logic              busy;
    logic              done;

    accumulator_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .reg_addr_in(reg_addr_in),
        .register_value(register_value), .register_address(register_address), .ce(ce),
        .accumulator_input(accumulator_input), .acc(acc), .carry(carry), .zero(zero),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] acc;
        logic              carry;
        int                done_cyc;
        int                ce_cnt;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ce_seen  = 0;

    // Register-file environment, with a poke port for setting operands.
    logic [DATA_W-1:0] tb_regs [4];
    logic [DATA_W-1:0] m_regs  [4];
    logic              poke_en  = 1'b0;
    logic [ADDR_W-1:0] poke_idx = '0;
    logic [DATA_W-1:0] poke_val = '0;

    assign register_value = tb_regs[register_address];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (poke_en)  tb_regs[poke_idx] <= poke_val;
        else if (ce)  tb_regs[register_address] <= accumulator_input;
    end

    logic [DATA_W-1:0] m_acc   = '0;
    logic              m_carry = 1'b0;
    int                left    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic accept(input logic [2:0] op, input logic [ADDR_W-1:0] ad);
        exp_t              e;
        logic [DATA_W-1:0] r;
        int unsigned       p;
        r = m_regs[ad];
        case (op)
            LD:  m_acc = r;
            ST:  m_regs[ad] = m_acc;
            ADD: begin
                p       = int'(m_acc) + int'(r);
                m_acc   = DATA_W'(p % 256);
                m_carry = (p > 255);
            end
            SUB: begin
                m_carry = (r > m_acc);
                m_acc   = DATA_W'((int'(m_acc) - int'(r) + 256) % 256);
            end
            AND: begin m_acc = m_acc & r; m_carry = 1'b0; end
            XOR: begin m_acc = m_acc ^ r; m_carry = 1'b0; end
            MUL: begin
                p       = int'(m_acc) * int'(r);
                m_acc   = DATA_W'(p % 256);
                m_carry = (p > 255);
            end
            default: ;
        endcase
        e.acc      = m_acc;
        e.carry    = m_carry;
        e.done_cyc = cyc + 2 + ((op == MUL) ? int'(DATA_W) : 0);
        e.ce_cnt   = (op == ST) ? 1 : 0;
        e.addr     = ad;
        sb.push_back(e);
        left = (op == MUL) ? int'(MUL_BUSY) : 2;
    endtask

    task automatic step(input logic st, input logic [2:0] op, input logic [ADDR_W-1:0] ad);
        @(negedge clk);
        chk("busy", 32'(busy), 32'(left != 0));
        poke_en     = 1'b0;
        start       = st;
        opcode      = op;
        reg_addr_in = ad;
        if (left > 0) left--;
        else if (st)  accept(op, ad);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (left != 0 && n < 100) begin
            step(1'b0, NOP, '0);
            n++;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [ADDR_W-1:0] ad);
        wait_idle();
        step(1'b1, op, ad);
    endtask

    task automatic set_reg(input int i, input logic [DATA_W-1:0] v);
        wait_idle();
        @(negedge clk);
        start      = 1'b0;
        poke_en    = 1'b1;
        poke_idx   = ADDR_W'(i);
        poke_val   = v;
        m_regs[i]  = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_acc"},   32'(acc),   32'(0));
        chk({tag, "_carry"}, 32'(carry), 32'(0));
        chk({tag, "_busy"},  32'(busy),  32'(0));
        chk({tag, "_done"},  32'(done),  32'(0));
        chk({tag, "_ce"},    32'(ce),    32'(0));
        chk({tag, "_zero"},  32'(zero),  32'(1));
        chk({tag, "_addr"},  32'(register_address), 32'(0));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ce_seen = 0;
        end else begin
            if (ce) ce_seen++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_done actual=1 expected=0 t=%0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("acc",      32'(acc),              32'(e.acc));
                    chk("carry",    32'(carry),            32'(e.carry));
                    chk("zero",     32'(zero),             32'(e.acc == 0));
                    chk("done_cyc", 32'(cyc),              32'(e.done_cyc));
                    chk("ce_count", 32'(ce_seen),          32'(e.ce_cnt));
                    chk("reg_addr", 32'(register_address), 32'(e.addr));
                end
                ce_seen = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; opcode = NOP; reg_addr_in = '0;
        for (int i = 0; i < 4; i++) begin tb_regs[i] = '0; m_regs[i] = '0; end
        #1;
        check_reset_outputs("rst0");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // LD/ADD wrap to zero with carry; ST writes back through ce.
        set_reg(0, 8'hA5); set_reg(1, 8'h0F); set_reg(2, 8'hF1); set_reg(3, 8'h00);
        issue(LD, 2'd1); issue(ADD, 2'd2);
        issue(LD, 2'd0); issue(ST, 2'd3);
        wait_idle();
        step(1'b0, NOP, '0);
        chk("st_r3", 32'(tb_regs[3]), 32'(8'hA5));

        // SUB with borrow, then XOR back to zero.
        set_reg(0, 8'h05); set_reg(1, 8'h07); set_reg(2, 8'hFE);
        issue(LD, 2'd0); issue(SUB, 2'd1); issue(XOR, 2'd2);

        // MUL with starts pulsed while busy.
        set_reg(0, 8'h10); set_reg(1, 8'h11);
        issue(LD, 2'd0); issue(MUL, 2'd1);
        repeat (4) step(1'b1, ADD, 2'd0);
        wait_idle();

        // start held high: one accept every three cycles.
        repeat (30) step(1'b1, 3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)));
        wait_idle();

        // Reset three cycles into a MUL.
        set_reg(0, 8'h37); set_reg(1, 8'hC3);
        issue(LD, 2'd0); issue(MUL, 2'd1);
        repeat (4) step(1'b0, NOP, '0);
        #2 rst = 1'b1;
        sb.delete();
        left = 0; m_acc = '0; m_carry = 1'b0;
        #1;
        check_reset_outputs("rst_mul");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) step(1'b0, NOP, '0);
        chk("post_rst_acc", 32'(acc), 32'(0));

        // Randomized traffic.
        for (int i = 0; i < 4; i++) set_reg(i, 8'($urandom_range(0, 255)));
        repeat (400) step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          2'($urandom_range(0, 3)));
        wait_idle();
        repeat (3) step(1'b0, NOP, '0);

        chk("sb_empty", 32'(sb.size()), 32'(0));
        for (int i = 0; i < 4; i++) chk("regfile", 32'(tb_regs[i]), 32'(m_regs[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
